// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - opcode/funct, ALU, selector encodings and the per-stage control bundle
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_SLL  = 3'd4;
    localparam logic [2:0] ALU_SLTU = 3'd6;
    localparam logic [2:0] ALU_LUI  = 3'd7;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_REG, PC_JUMP} pc_sel_t;
    typedef enum logic [1:0] {M2R_ALU, M2R_PC8, M2R_MEM} mem_to_reg_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        mem_to_reg_t mem_to_reg;
        logic        alu_a_src;
        logic        alu_b_src;
        logic [2:0]  alu_ctrl;
        logic        md_start;
        logic        is_load;
    } ctrl_bundle_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// rtl/pipe_ctrl_decode.sv - combinational D-stage decode of one instruction into the control bundle
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr,
    input  logic              cmp_eq,
    output ctrl_bundle_t      ctrl,
    output logic [REG_AW-1:0] dst,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic              reads_rs,
    output logic              reads_rt,
    output logic [1:0]        pc_sel,
    output logic              ext_op,
    output logic              is_br,
    output logic              is_md
);

    logic [5:0]        op;
    logic [5:0]        fn;
    logic [4:0]        dst5;
    logic [REG_AW-1:0] dst_t;
    logic              wr;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rs = REG_AW'(instr[25:21]);
    assign rt = REG_AW'(instr[20:16]);

    // shamt is consumed by the datapath, not by control
    wire unused_shamt = ^instr[10:6];

    always_comb begin
        ctrl     = '0;
        wr       = 1'b0;
        dst5     = 5'd0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        pc_sel   = PC_PLUS4;
        ext_op   = 1'b0;
        is_br    = 1'b0;
        is_md    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        wr = 1'b1; dst5 = instr[15:11];
                        reads_rs = 1'b1; reads_rt = 1'b1;
                        ctrl.alu_ctrl = (fn == FN_ADDU) ? ALU_ADD : ALU_SUB;
                    end
                    FN_SLL: begin
                        wr = 1'b1; dst5 = instr[15:11]; reads_rt = 1'b1;
                        ctrl.alu_ctrl = ALU_SLL; ctrl.alu_a_src = 1'b1;
                    end
                    FN_JR: begin
                        reads_rs = 1'b1; pc_sel = PC_REG; is_br = 1'b1;
                    end
                    FN_JALR: begin
                        reads_rs = 1'b1; pc_sel = PC_REG; is_br = 1'b1;
                        wr = 1'b1; dst5 = 5'd31; ctrl.mem_to_reg = M2R_PC8;
                    end
                    FN_MULT, FN_DIV: begin
                        reads_rs = 1'b1; reads_rt = 1'b1;
                        ctrl.md_start = 1'b1; is_md = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        wr = 1'b1; dst5 = instr[15:11]; is_md = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                wr = 1'b1; dst5 = instr[20:16]; reads_rs = 1'b1;
                ctrl.alu_ctrl = ALU_OR; ctrl.alu_b_src = 1'b1;
            end
            OP_LUI: begin
                wr = 1'b1; dst5 = instr[20:16];
                ctrl.alu_ctrl = ALU_LUI; ctrl.alu_b_src = 1'b1;
            end
            OP_SLTIU, OP_ADDIU: begin
                wr = 1'b1; dst5 = instr[20:16]; reads_rs = 1'b1; ext_op = 1'b1;
                ctrl.alu_ctrl = (op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
                ctrl.alu_b_src = 1'b1;
            end
            OP_LW: begin
                wr = 1'b1; dst5 = instr[20:16]; reads_rs = 1'b1; ext_op = 1'b1;
                ctrl.alu_ctrl = ALU_ADD; ctrl.alu_b_src = 1'b1;
                ctrl.mem_to_reg = M2R_MEM; ctrl.is_load = 1'b1;
            end
            OP_SW: begin
                reads_rs = 1'b1; reads_rt = 1'b1; ext_op = 1'b1;
                ctrl.alu_ctrl = ALU_ADD; ctrl.alu_b_src = 1'b1; ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                reads_rs = 1'b1; reads_rt = 1'b1; ext_op = 1'b1; is_br = 1'b1;
                pc_sel = cmp_eq ? PC_BRANCH : PC_PLUS4;
            end
            OP_J:   pc_sel = PC_JUMP;
            OP_JAL: begin
                pc_sel = PC_JUMP; wr = 1'b1; dst5 = 5'd31; ctrl.mem_to_reg = M2R_PC8;
            end
            default: ;
        endcase
        // a write to register 0 is dropped here so no later stage ever sees it
        dst_t          = REG_AW'(dst5);
        ctrl.reg_write = wr && (dst_t != '0);
        dst            = ctrl.reg_write ? dst_t : '0;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - 5-stage control: decode, E/M/W bundles, hazards, md counter; PIPE_CTRL_FWD_EN enables forwarding
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 5,
    parameter int ALUC_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_d,
    input  logic              cmp_eq_d,
    output logic              stall_d,
    output logic [1:0]        pc_sel_d,
    output logic              ext_op_d,
    output logic              alu_a_src_e,
    output logic              alu_b_src_e,
    output logic [ALUC_W-1:0] alu_ctrl_e,
    output logic              md_start_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mem_write_m,
    output logic              reg_write_w,
    output logic [REG_AW-1:0] wr_addr_w,
    output logic [1:0]        mem_to_reg_w,
    output logic              md_busy
);

    ctrl_bundle_t      dec, ctrl_e;
    logic [REG_AW-1:0] dst_d, rs_d, rt_d, dst_e, dst_m;
    logic              reads_rs_d, reads_rt_d, is_br_d, is_md_d;
    logic [1:0]        pc_sel_raw;
    logic              reg_write_m, is_load_m;
    mem_to_reg_t       mem_to_reg_m, mem_to_reg_q;
    logic [4:0]        md_cnt;
    logic              src_hit_e, src_hit_m, haz_a, haz_b, haz_c;

    pipe_ctrl_decode #(.REG_AW(REG_AW)) u_decode (
        .instr    (instr_d),
        .cmp_eq   (cmp_eq_d),
        .ctrl     (dec),
        .dst      (dst_d),
        .rs       (rs_d),
        .rt       (rt_d),
        .reads_rs (reads_rs_d),
        .reads_rt (reads_rt_d),
        .pc_sel   (pc_sel_raw),
        .ext_op   (ext_op_d),
        .is_br    (is_br_d),
        .is_md    (is_md_d)
    );

    // reg_write already implies a non-zero destination, so $0 never hits
    assign src_hit_e = ctrl_e.reg_write &&
                       ((reads_rs_d && rs_d == dst_e) || (reads_rt_d && rt_d == dst_e));
    assign src_hit_m = reg_write_m &&
                       ((reads_rs_d && rs_d == dst_m) || (reads_rt_d && rt_d == dst_m));

    assign haz_a = ctrl_e.is_load && src_hit_e;
    assign haz_b = is_br_d && (src_hit_e || (is_load_m && src_hit_m));
    assign haz_c = is_md_d && (md_busy || ctrl_e.md_start);

`ifdef PIPE_CTRL_FWD_EN
    assign stall_d = haz_a || haz_b || haz_c;
`else
    assign stall_d = haz_a || haz_b || haz_c || src_hit_e || src_hit_m;
`endif

    assign pc_sel_d     = stall_d ? PC_PLUS4 : pc_sel_raw;
    assign alu_a_src_e  = ctrl_e.alu_a_src;
    assign alu_b_src_e  = ctrl_e.alu_b_src;
    assign alu_ctrl_e   = ALUC_W'(ctrl_e.alu_ctrl);
    assign md_start_e   = ctrl_e.md_start;
    assign mem_to_reg_w = mem_to_reg_q;
    assign md_busy      = (md_cnt != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e       <= '0;
            dst_e        <= '0;
            reg_write_m  <= 1'b0;
            is_load_m    <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= M2R_ALU;
            dst_m        <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_q <= M2R_ALU;
            wr_addr_w    <= '0;
            md_cnt       <= 5'd0;
        end else begin
            if (stall_d) begin
                ctrl_e <= '0;
                dst_e  <= '0;
            end else begin
                ctrl_e <= dec;
                dst_e  <= dst_d;
            end
            reg_write_m  <= ctrl_e.reg_write;
            is_load_m    <= ctrl_e.is_load;
            mem_write_m  <= ctrl_e.mem_write;
            mem_to_reg_m <= ctrl_e.mem_to_reg;
            dst_m        <= dst_e;
            reg_write_w  <= reg_write_m;
            mem_to_reg_q <= mem_to_reg_m;
            wr_addr_w    <= dst_m;
            if (!stall_d && dec.md_start)
                md_cnt <= 5'(MD_LATENCY);
            else if (md_cnt != 5'd0)
                md_cnt <= md_cnt - 5'd1;
        end
    end

`ifdef PIPE_CTRL_FWD_EN
    logic [REG_AW-1:0] rs_e, rt_e;
    logic              reads_rs_e, reads_rt_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_e <= '0; rt_e <= '0; reads_rs_e <= 1'b0; reads_rt_e <= 1'b0;
        end else if (stall_d) begin
            rs_e <= '0; rt_e <= '0; reads_rs_e <= 1'b0; reads_rt_e <= 1'b0;
        end else begin
            rs_e <= rs_d; rt_e <= rt_d; reads_rs_e <= reads_rs_d; reads_rt_e <= reads_rt_d;
        end
    end

    // M is younger than W, so it wins when both hold the same register
    always_comb begin
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        if (reads_rs_e && reg_write_m && dst_m == rs_e)          fwd_a_e = FWD_M;
        else if (reads_rs_e && reg_write_w && wr_addr_w == rs_e) fwd_a_e = FWD_W;
        if (reads_rt_e && reg_write_m && dst_m == rt_e)          fwd_b_e = FWD_M;
        else if (reads_rt_e && reg_write_w && wr_addr_w == rt_e) fwd_b_e = FWD_W;
    end
`else
    assign fwd_a_e = FWD_RF;
    assign fwd_b_e = FWD_RF;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed checks of decode, stalls, forwarding, md counter and reset
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_d = 32'h0;
    logic        cmp_eq_d = 1'b0;
    logic        stall_d, ext_op_d, alu_a_src_e, alu_b_src_e, md_start_e;
    logic        mem_write_m, reg_write_w, md_busy;
    logic [1:0]  pc_sel_d, fwd_a_e, fwd_b_e, mem_to_reg_w;
    logic [2:0]  alu_ctrl_e;
    logic [4:0]  wr_addr_w;
    int          checks = 0;
    int          errors = 0;

    pipe_ctrl_unit #(.REG_AW(5), .MD_LATENCY(5), .ALUC_W(3)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .cmp_eq_d(cmp_eq_d),
        .stall_d(stall_d), .pc_sel_d(pc_sel_d), .ext_op_d(ext_op_d),
        .alu_a_src_e(alu_a_src_e), .alu_b_src_e(alu_b_src_e), .alu_ctrl_e(alu_ctrl_e),
        .md_start_e(md_start_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .mem_write_m(mem_write_m), .reg_write_w(reg_write_w), .wr_addr_w(wr_addr_w),
        .mem_to_reg_w(mem_to_reg_w), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        instr_d = NOP;
        cmp_eq_d = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset;
        instr_d = NOP;
        repeat (2) tick();
        checks++; if ({stall_d, pc_sel_d, ext_op_d, alu_a_src_e, alu_b_src_e, alu_ctrl_e, md_start_e, fwd_a_e, fwd_b_e, mem_write_m, reg_write_w, wr_addr_w, mem_to_reg_w, md_busy} !== '0) begin errors++; $display("FAIL reset_outputs: got nonzero outputs stall=%0b wr_addr=%0d busy=%0b", stall_d, wr_addr_w, md_busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use;
        instr_d = itype(6'h23, 5'd0, 5'd8, 16'd0); #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_lw_nostall: got %0b want 0", stall_d); end
        checks++; if (ext_op_d !== 1'b1) begin errors++; $display("FAIL lu_lw_ext: got %0b want 1", ext_op_d); end
        tick(); instr_d = rtype(5'd8, 5'd8, 5'd9, 6'h21); #1;
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %0b want 1", stall_d); end
        checks++; if (alu_ctrl_e !== 3'd2 || alu_b_src_e !== 1'b1) begin errors++; $display("FAIL lu_lw_in_e: got alu=%0d bsrc=%0b want 2 1", alu_ctrl_e, alu_b_src_e); end
        tick(); #1;
        checks++; if (alu_ctrl_e !== 3'd0) begin errors++; $display("FAIL lu_e_bubble: got alu=%0d want 0", alu_ctrl_e); end
`ifdef PIPE_CTRL_FWD_EN
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %0b want 0", stall_d); end
        tick(); instr_d = NOP; #1;
`else
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_stall2: got %0b want 1", stall_d); end
        tick(); #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_stall3: got %0b want 0", stall_d); end
        checks++; if (reg_write_w !== 1'b1 || wr_addr_w !== 5'd8 || mem_to_reg_w !== 2'd2) begin errors++; $display("FAIL lu_lw_w: got rw=%0b addr=%0d m2r=%0d want 1 8 2", reg_write_w, wr_addr_w, mem_to_reg_w); end
        tick(); instr_d = NOP; #1;
`endif
`ifdef PIPE_CTRL_FWD_EN
        checks++; if (fwd_a_e !== 2'd2 || fwd_b_e !== 2'd2) begin errors++; $display("FAIL lu_fwd: got a=%0d b=%0d want 2 2", fwd_a_e, fwd_b_e); end
        checks++; if (reg_write_w !== 1'b1 || wr_addr_w !== 5'd8 || mem_to_reg_w !== 2'd2) begin errors++; $display("FAIL lu_lw_w: got rw=%0b addr=%0d m2r=%0d want 1 8 2", reg_write_w, wr_addr_w, mem_to_reg_w); end
`else
        checks++; if (fwd_a_e !== 2'd0 || fwd_b_e !== 2'd0) begin errors++; $display("FAIL lu_fwd: got a=%0d b=%0d want 0 0", fwd_a_e, fwd_b_e); end
`endif
        checks++; if (alu_ctrl_e !== 3'd2) begin errors++; $display("FAIL lu_addu_e: got alu=%0d want 2", alu_ctrl_e); end
        drain();
    endtask

    task automatic test_branch;
        instr_d = itype(6'h0D, 5'd0, 5'd3, 16'd5); #1;
        checks++; if (stall_d !== 1'b0 || ext_op_d !== 1'b0) begin errors++; $display("FAIL br_ori: got stall=%0b ext=%0b want 0 0", stall_d, ext_op_d); end
        tick(); instr_d = itype(6'h04, 5'd3, 5'd3, 16'd4); cmp_eq_d = 1'b1; #1;
        checks++; if (stall_d !== 1'b1 || pc_sel_d !== 2'd0) begin errors++; $display("FAIL br_stall: got stall=%0b pc_sel=%0d want 1 0", stall_d, pc_sel_d); end
        checks++; if (ext_op_d !== 1'b1) begin errors++; $display("FAIL br_ext: got %0b want 1", ext_op_d); end
        tick();
`ifndef PIPE_CTRL_FWD_EN
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL br_stall2: got %0b want 1", stall_d); end
        tick();
`endif
        checks++; if (stall_d !== 1'b0 || pc_sel_d !== 2'd1) begin errors++; $display("FAIL br_taken: got stall=%0b pc_sel=%0d want 0 1", stall_d, pc_sel_d); end
        tick(); instr_d = itype(6'h09, 5'd0, 5'd10, 16'd1); cmp_eq_d = 1'b0; #1;
        checks++; if (stall_d !== 1'b0 || pc_sel_d !== 2'd0) begin errors++; $display("FAIL br_slot_d: got stall=%0b pc_sel=%0d want 0 0", stall_d, pc_sel_d); end
        tick(); instr_d = NOP;
        tick(); tick();
        checks++; if (reg_write_w !== 1'b1 || wr_addr_w !== 5'd10 || mem_to_reg_w !== 2'd0) begin errors++; $display("FAIL br_slot_w: got rw=%0b addr=%0d m2r=%0d want 1 10 0", reg_write_w, wr_addr_w, mem_to_reg_w); end
        drain();
    endtask

    task automatic test_muldiv;
        int n;
        instr_d = rtype(5'd4, 5'd5, 5'd0, 6'h18); #1;
        checks++; if (stall_d !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL md_mult_d: got stall=%0b busy=%0b want 0 0", stall_d, md_busy); end
        tick(); instr_d = rtype(5'd0, 5'd0, 5'd6, 6'h12); #1;
        checks++; if (md_start_e !== 1'b1 || md_busy !== 1'b1) begin errors++; $display("FAIL md_start: got start=%0b busy=%0b want 1 1", md_start_e, md_busy); end
        n = 0;
        while (stall_d === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL md_stall_cycles: got %0d want 5", n); end
        checks++; if (md_busy !== 1'b0 || md_start_e !== 1'b0) begin errors++; $display("FAIL md_idle: got busy=%0b start=%0b want 0 0", md_busy, md_start_e); end
        tick(); instr_d = NOP;
        tick(); tick();
        checks++; if (reg_write_w !== 1'b1 || wr_addr_w !== 5'd6 || mem_to_reg_w !== 2'd0) begin errors++; $display("FAIL md_mflo_w: got rw=%0b addr=%0d m2r=%0d want 1 6 0", reg_write_w, wr_addr_w, mem_to_reg_w); end
        drain();
    endtask

    task automatic test_jump;
        instr_d = {6'h03, 26'h0000100}; #1;
        checks++; if (pc_sel_d !== 2'd3 || stall_d !== 1'b0) begin errors++; $display("FAIL jal_pcsel: got pc_sel=%0d stall=%0b want 3 0", pc_sel_d, stall_d); end
        tick(); instr_d = rtype(5'd2, 5'd0, 5'd0, 6'h08); #1;
        checks++; if (pc_sel_d !== 2'd2) begin errors++; $display("FAIL jr_pcsel: got %0d want 2", pc_sel_d); end
        tick(); instr_d = itype(6'h2B, 5'd0, 5'd2, 16'd4); #1;
        tick(); instr_d = NOP; #1;
        checks++; if (reg_write_w !== 1'b1 || wr_addr_w !== 5'd31 || mem_to_reg_w !== 2'd1) begin errors++; $display("FAIL jal_w: got rw=%0b addr=%0d m2r=%0d want 1 31 1", reg_write_w, wr_addr_w, mem_to_reg_w); end
        tick();
        checks++; if (mem_write_m !== 1'b1) begin errors++; $display("FAIL sw_m: got %0b want 1", mem_write_m); end
        drain();
    endtask

    task automatic test_reg_zero;
        instr_d = rtype(5'd1, 5'd2, 5'd0, 6'h21); #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL r0_stall_a: got %0b want 0", stall_d); end
        tick(); instr_d = rtype(5'd0, 5'd0, 5'd7, 6'h21); #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL r0_stall_b: got %0b want 0", stall_d); end
        tick(); instr_d = NOP; #1;
        checks++; if (fwd_a_e !== 2'd0 || fwd_b_e !== 2'd0) begin errors++; $display("FAIL r0_fwd: got a=%0d b=%0d want 0 0", fwd_a_e, fwd_b_e); end
        tick();
        checks++; if (reg_write_w !== 1'b0 || wr_addr_w !== 5'd0) begin errors++; $display("FAIL r0_w: got rw=%0b addr=%0d want 0 0", reg_write_w, wr_addr_w); end
        tick();
        checks++; if (reg_write_w !== 1'b1 || wr_addr_w !== 5'd7) begin errors++; $display("FAIL r7_w: got rw=%0b addr=%0d want 1 7", reg_write_w, wr_addr_w); end
        drain();
    endtask

    task automatic test_back_to_back;
        instr_d = rtype(5'd1, 5'd2, 5'd12, 6'h21); #1;
        tick(); instr_d = rtype(5'd3, 5'd4, 5'd12, 6'h21); #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL b2b_i2: got stall=%0b want 0", stall_d); end
        tick(); instr_d = rtype(5'd12, 5'd12, 5'd13, 6'h23); #1;
`ifdef PIPE_CTRL_FWD_EN
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL b2b_i3: got stall=%0b want 0", stall_d); end
        tick(); instr_d = NOP; #1;
        checks++; if (fwd_a_e !== 2'd1 || fwd_b_e !== 2'd1) begin errors++; $display("FAIL b2b_fwd_m: got a=%0d b=%0d want 1 1", fwd_a_e, fwd_b_e); end
`else
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL b2b_i3: got stall=%0b want 1", stall_d); end
        tick();
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL b2b_i3b: got stall=%0b want 1", stall_d); end
        tick();
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL b2b_i3c: got stall=%0b want 0", stall_d); end
        tick(); instr_d = NOP; #1;
        checks++; if (fwd_a_e !== 2'd0 || fwd_b_e !== 2'd0) begin errors++; $display("FAIL b2b_fwd: got a=%0d b=%0d want 0 0", fwd_a_e, fwd_b_e); end
`endif
        checks++; if (alu_ctrl_e !== 3'd3) begin errors++; $display("FAIL b2b_subu_e: got alu=%0d want 3", alu_ctrl_e); end
        drain();
    endtask

    task automatic test_async_reset;
        instr_d = itype(6'h23, 5'd0, 5'd8, 16'd0); #1;
        tick(); instr_d = rtype(5'd8, 5'd8, 5'd9, 6'h21); #1;
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL ar_pre_stall: got %0b want 1", stall_d); end
        #2 reset = 1'b1; #1;
        checks++; if ({stall_d, pc_sel_d, ext_op_d, alu_a_src_e, alu_b_src_e, alu_ctrl_e, md_start_e, fwd_a_e, fwd_b_e, mem_write_m, reg_write_w, wr_addr_w, mem_to_reg_w, md_busy} !== '0) begin errors++; $display("FAIL ar_outputs: got stall=%0b alu=%0d bsrc=%0b want 0 0 0", stall_d, alu_ctrl_e, alu_b_src_e); end
        tick();
        reset = 1'b0; #1;
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL ar_release_stall: got %0b want 0", stall_d); end
        tick(); instr_d = NOP; #1;
        checks++; if (alu_ctrl_e !== 3'd2 || fwd_a_e !== 2'd0 || fwd_b_e !== 2'd0) begin errors++; $display("FAIL ar_resume: got alu=%0d a=%0d b=%0d want 2 0 0", alu_ctrl_e, fwd_a_e, fwd_b_e); end
        drain();
        instr_d = rtype(5'd4, 5'd5, 5'd0, 6'h1A); #1;
        tick(); instr_d = NOP; #1;
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL ar_div_busy: got %0b want 1", md_busy); end
        #2 reset = 1'b1; #1;
        checks++; if (md_busy !== 1'b0 || md_start_e !== 1'b0) begin errors++; $display("FAIL ar_md_clear: got busy=%0b start=%0b want 0 0", md_busy, md_start_e); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL ar_md_after: got %0b want 0", md_busy); end
        drain();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_jump();
        test_reg_zero();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
